// File: rtl/wallace_mac_if.sv
// rtl/wallace_mac_if.sv - operand/result handshake bundle for wallace_mac
interface wallace_mac_if #(
    parameter int ACC_W = 40,
    parameter int LEN_W = 8
) ();
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      a;
    logic [15:0]      b;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic             overflow;
    logic             busy;

    modport master (
        output start, len, in_valid, a, b, out_ready,
        input  in_ready, out_valid, acc_out, overflow, busy
    );

    modport slave (
        input  start, len, in_valid, a, b, out_ready,
        output in_ready, out_valid, acc_out, overflow, busy
    );
endinterface

// File: rtl/wallace_mac.sv
// rtl/wallace_mac.sv - burst multiply-accumulate stage around a 16x16 Wallace-tree multiplier
module wallace_multiplier (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [31:0] o_p
);
    logic [31:0] w_rows [16];
    logic [31:0] w_next [16];

    // Row-level 3:2 carry-save reduction: 16 -> 11 -> 8 -> 6 -> 4 -> 3 -> 2 rows.
    always_comb begin
        int n;
        int m;
        for (int i = 0; i < 16; i++)
            w_rows[i] = i_b[i] ? (32'(i_a) << i) : 32'd0;
        n = 16;
        for (int s = 0; s < 6; s++) begin
            w_next = '{default: '0};
            m = 0;
            for (int g = 0; g < 5; g++) begin
                if (3 * g + 2 < n) begin
                    w_next[4'(m)]     = w_rows[4'(3*g)] ^ w_rows[4'(3*g+1)] ^ w_rows[4'(3*g+2)];
                    w_next[4'(m + 1)] = ((w_rows[4'(3*g)] & w_rows[4'(3*g+1)]) |
                                         (w_rows[4'(3*g)] & w_rows[4'(3*g+2)]) |
                                         (w_rows[4'(3*g+1)] & w_rows[4'(3*g+2)])) << 1;
                    m = m + 2;
                end
            end
            for (int j = 0; j < 16; j++) begin
                if (j >= 3 * (n / 3) && j < n) begin
                    w_next[4'(m)] = w_rows[j];
                    m = m + 1;
                end
            end
            w_rows = w_next;
            n = m;
        end
        o_p = w_rows[0] + w_rows[1];
    end
endmodule

module wallace_mac #(
    parameter int ACC_W = 40,
    parameter int LEN_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    wallace_mac_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic [15:0]      r_a;
    logic [15:0]      r_b;
    logic             r_v1;
    logic [31:0]      r_p;
    logic             r_v2;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [31:0]      w_prod;
    logic             w_xfer;
    logic             w_last;
    logic             w_start;
    logic [ACC_W:0]   w_sum;

    wallace_multiplier u_mul (
        .i_a (r_a),
        .i_b (r_b),
        .o_p (w_prod)
    );

    assign w_xfer  = bus.in_valid && (r_state == S_RUN);
    assign w_last  = w_xfer && ((r_cnt + LEN_W'(1)) == r_len);
    assign w_start = bus.start && (r_state == S_IDLE);
    assign w_sum   = {1'b0, r_acc} + (ACC_W+1)'(r_p);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next_state = (bus.len != '0) ? S_RUN : S_DONE;
            S_RUN:   if (w_last) w_next_state = S_DRAIN;
            // With no new accepts, S1 empty now means both stages are empty after this edge.
            S_DRAIN: if (!r_v1) w_next_state = S_DONE;
            S_DONE:  if (bus.out_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_v1    <= 1'b0;
            r_p     <= '0;
            r_v2    <= 1'b0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_v1    <= w_xfer;
            r_v2    <= r_v1;
            if (w_xfer) begin
                r_a <= bus.a;
                r_b <= bus.b;
            end
            if (r_v1)
                r_p <= w_prod;
            if (w_start) begin
                r_len <= bus.len;
                r_cnt <= '0;
                r_acc <= '0;
                r_ovf <= 1'b0;
            end else begin
                if (w_xfer)
                    r_cnt <= r_cnt + LEN_W'(1);
                if (r_v2) begin
                    r_acc <= w_sum[ACC_W-1:0];
                    r_ovf <= r_ovf | w_sum[ACC_W];
                end
            end
        end
    end

    assign bus.in_ready  = (r_state == S_RUN);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.acc_out   = r_acc;
    assign bus.overflow  = r_ovf;
endmodule

// File: doc/wallace_mac.md
# wallace_mac

Sequential multiply-accumulate stage wrapped around the 16-bit `wallace_multiplier`. It accepts a counted burst of unsigned 16-bit operand pairs over a valid/ready handshake. The operands are registered ahead of the combinational Wallace tree, and the 32-bit product is registered after it. Each product is summed into a wide accumulator, and the final sum is presented on a valid/ready output port. The block feeds the multiplier and consumes its product; it is the datapath stage directly around the existing tree.

## Interface

Parameters:
- `ACC_W`, default 40: accumulator and result width. Must be at least 32.
- `LEN_W`, default 8: width of the burst-length field.

Ports:
- `clk`, input, 1: single clock. All state updates occur on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `start`, input, 1: begins a burst. Sampled only in IDLE.
- `len`, input, LEN_W: number of operand pairs in the burst. Sampled with `start`.
- `in_valid`, input, 1: operand pair on `a`/`b` is valid.
- `in_ready`, output, 1: block accepts an operand pair this cycle.
- `a`, input, 16: unsigned multiplicand.
- `b`, input, 16: unsigned multiplier.
- `out_valid`, output, 1: `acc_out` holds the final burst sum.
- `out_ready`, input, 1: consumer takes the result.
- `acc_out`, output, ACC_W: accumulated sum.
- `overflow`, output, 1: sticky flag; the sum exceeded ACC_W bits during the burst.
- `busy`, output, 1: high in every state except IDLE.

## Operation

- Pipeline stages:
  - S1: `a`/`b` registers plus a valid bit.
  - `wallace_multiplier` instance, driven combinationally from S1.
  - S2: 32-bit product register plus a valid bit.
  - ACC: accumulate register.
- State machine: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `in_ready`=0, `out_valid`=0.
  - `start`=1 with `len`≠0: latch `len`, clear the accept counter, accumulator and `overflow`; go to RUN.
  - `start`=1 with `len`=0: clear the accumulator and `overflow`; go to DONE.
- RUN:
  - `in_ready`=1.
  - A transfer occurs when `in_valid`&`in_ready` is high at an edge. It loads S1 and increments the accept counter.
  - On the transfer that brings the counter to `len`, go to DRAIN. `in_ready` is 0 from the next cycle.
- DRAIN:
  - `in_ready`=0.
  - Go to DONE on the edge at which the last valid product is added, i.e. when S1 and S2 are both empty after that edge.
- DONE:
  - `out_valid`=1. `acc_out` and `overflow` are held stable.
  - `out_ready`=1 at an edge: go to IDLE.
- Every S2-valid cycle adds the zero-extended product to the accumulator: `acc <= acc + {0, p}`, truncated to ACC_W.
- `overflow` is set if the add carries out of bit ACC_W-1. It stays set until the next `start`.
- `start` outside IDLE is ignored.
- Gaps in `in_valid` insert bubbles into the pipeline. The result is unaffected.
- `acc_out` is driven directly from the accumulator at all times. Consumers qualify it with `out_valid`.
- Reset behaviour:
  - State returns to IDLE. S1/S2 valid bits, accumulator, counter and `overflow` are cleared.
  - `in_ready`, `out_valid`, `busy`, `acc_out` and `overflow` all read 0.
  - Reset mid-burst discards all in-flight data.

## Timing

- Last operand accepted at edge E0 → product registered at E1 → accumulated at E2. `out_valid` is high in the cycle after E2. Latency is 2 edges from the last accept to result.
- Throughput: one pair per cycle while `in_valid` is held high.
- `len`=0: `out_valid` goes high the cycle after the `start` edge.
- `out_valid` with `out_ready` high: IDLE after that edge. A new `start` is accepted on the following edge.
- `rst` wins over all other inputs in the same cycle.

## Test plan

- **Single pair.** After reset, `start`, `len`=1, a=3, b=5 → `out_valid` 2 edges after the accept, `acc_out`=15, `overflow`=0.
- **Maximum operands.** `len`=4, four pairs of 65535×65535 back-to-back → `acc_out`=17179344900, `overflow`=0. `in_ready` falls after the 4th accept.
- **Zero length.** `start` with `len`=0 → `out_valid` high the next cycle, `acc_out`=0. No input handshake occurs.
- **Back-pressure.**
  - `len`=3 with `in_valid` gaps of 2 cycles; pairs (100,200), (7,9), (0,65535) → `acc_out`=20063.
  - Hold `out_ready`=0 for 5 cycles and pulse `start` during DONE → `out_valid` and `acc_out` stay stable and `start` is ignored.
- **Overflow.** ACC_W=33, `len`=3, three pairs of 65535×65535 → `acc_out`=4294574083, `overflow`=1. A following `start` clears `overflow`.
- **Reset mid-burst.** Assert `rst` during RUN after 1 of `len`=4 accepted → all outputs 0 and state IDLE the next cycle. A new burst `len`=2, pairs (1000,1000), (2,3) → `acc_out`=1000006.
